// File: rtl/usb_tx_arbiter.sv
// Round-robin arbiter sharing one USB transmit datapath between NUM_REQ packet sources.
// Define USB_TX_ARB_PRIO_EN to give requester 0 strict priority when idle.
module usb_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned GAP_CYCLES    = 8,
  parameter int unsigned MAX_PKT_BYTES = 64
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_valid,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_ready,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       grant_active,
  output logic                       pkt_overflow,
  output logic                       pkt_abort
);

  localparam int unsigned IDX_W    = $clog2(NUM_REQ);
  localparam int unsigned CNT_W    = 10;
  localparam int unsigned GAP_W    = (GAP_CYCLES < 16) ? 4 : $clog2(GAP_CYCLES + 1);
  localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

  typedef enum logic [1:0] {IDLE, SEND, EOP_WAIT, GAP} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               pkt_overflow_q, pkt_overflow_d;
  logic               pkt_abort_q, pkt_abort_d;

  logic               win_found;
  logic               win_upd;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   scan_idx;
  logic               gnt_valid;
  logic               gnt_last;
  logic [DATA_W-1:0]  gnt_data;
  logic               xfer;

  // Winner search: first valid requester above the last grant, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_upd   = 1'b1;
    scan_idx  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      scan_idx = IDX_W'((32'(last_grant_q) + i) % NUM_REQ);
`ifdef USB_TX_ARB_PRIO_EN
      if (!win_found && (scan_idx != '0) && req_valid[scan_idx]) begin
`else
      if (!win_found && req_valid[scan_idx]) begin
`endif
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
`ifdef USB_TX_ARB_PRIO_EN
    // Control endpoint preempts the rotation and leaves the pointer untouched.
    if (req_valid[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
      win_upd   = 1'b0;
    end
`endif
  end

  // Select the granted requester's handshake and byte.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    gnt_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == IDX_W'(i)) begin
        gnt_valid = req_valid[i];
        gnt_last  = req_last[i];
        gnt_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q        <= IDLE;
      grant_id_q     <= '0;
      last_grant_q   <= IDX_W'(NUM_REQ - 1);
      byte_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      pkt_overflow_q <= 1'b0;
      pkt_abort_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_id_q     <= grant_id_d;
      last_grant_q   <= last_grant_d;
      byte_cnt_q     <= byte_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      pkt_overflow_q <= pkt_overflow_d;
      pkt_abort_q    <= pkt_abort_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_id_d     = grant_id_q;
    last_grant_d   = last_grant_q;
    byte_cnt_d     = byte_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    pkt_overflow_d = 1'b0;
    pkt_abort_d    = 1'b0;
    tx_valid       = 1'b0;
    tx_data        = '0;
    req_ready      = '0;
    xfer           = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found && !tx_busy) begin
          grant_id_d = win_idx;
          if (win_upd) begin
            last_grant_d = win_idx;
          end
          byte_cnt_d = '0;
          state_d    = SEND;
        end
      end

      SEND: begin
        tx_valid = gnt_valid;
        tx_data  = gnt_data;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = (grant_id_q == IDX_W'(i)) && tx_ready;
        end
        xfer = gnt_valid && tx_ready;
        if (xfer) begin
          if (byte_cnt_q != '1) begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
          // A last byte landing exactly on the limit is a normal end, not an overflow.
          if (gnt_last) begin
            state_d = EOP_WAIT;
          end else if ((byte_cnt_q + CNT_W'(1)) == CNT_W'(MAX_PKT_BYTES)) begin
            pkt_overflow_d = 1'b1;
            state_d        = EOP_WAIT;
          end
        end else if (!gnt_valid && (byte_cnt_q != '0)) begin
          pkt_abort_d = 1'b1;
          state_d     = EOP_WAIT;
        end
      end

      EOP_WAIT: begin
        if (!tx_busy) begin
          gap_cnt_d = '0;
          state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end

      GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign grant_id     = grant_id_q;
  assign grant_active = (state_q == SEND) || (state_q == EOP_WAIT);
  assign pkt_overflow = pkt_overflow_q;
  assign pkt_abort    = pkt_abort_q;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Scoreboard bench for usb_tx_arbiter: requester byte queues feed the DUT, a monitor checks every transfer.
module tb_usb_tx_arbiter;

  localparam int unsigned NR   = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned GAPC = 8;
  localparam int unsigned MAXB = 4;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic             clk;
  logic             nRST;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic             tx_valid;
  logic [DW-1:0]    tx_data;
  logic             tx_ready;
  logic             tx_busy;
  logic [1:0]       grant_id;
  logic             grant_active;
  logic             pkt_overflow;
  logic             pkt_abort;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t exp_q[$];

  logic [8:0]  mem  [NR][64];
  int unsigned head [NR] = '{default: 0};
  int unsigned tail [NR] = '{default: 0};

  usb_tx_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .GAP_CYCLES(GAPC), .MAX_PKT_BYTES(MAXB)
  ) dut (
    .clk(clk), .nRST(nRST),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .tx_busy(tx_busy),
    .grant_id(grant_id), .grant_active(grant_active),
    .pkt_overflow(pkt_overflow), .pkt_abort(pkt_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester model: present queued bytes, advance on acknowledge.
  always_comb begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < int'(NR); i++) begin
      req_valid[i]          = (head[i] != tail[i]);
      req_data[i*DW +: DW]  = mem[i][6'(head[i])][7:0];
      req_last[i]           = mem[i][6'(head[i])][8];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < int'(NR); i++) begin
      if (req_valid[i] && req_ready[i]) head[i] <= head[i] + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    mem[r][6'(tail[r])] = {l, d};
    tail[r] = tail[r] + 1;
  endtask

  task automatic expect_x(input int r, input logic [7:0] d);
    exp_q.push_back('{id: 2'(r), data: d});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (((exp_q.size() != 0) || grant_active) && (n < 300)) begin
      next_cycle();
      n++;
    end
    chk("settle_timeout", 32'(n < 300), 32'd1);
    repeat (GAPC + 4) next_cycle();
  endtask

  // Monitor: every accepted byte must match the next scoreboard entry.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  always @(negedge clk) begin
    exp_t e;
    if (nRST) begin
      if (prev_stall) begin
        chk("hold_valid", 32'(tx_valid), 32'd1);
        chk("hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_xfer: actual id=%0d data=0x%0h required=none", grant_id, tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_id", 32'(grant_id), 32'(e.id));
          chk("xfer_data", 32'(tx_data), 32'(e.data));
          chk("xfer_ready", 32'(req_ready), 32'(4'b0001 << e.id));
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned h;
    nRST     = 1'b0;
    tx_ready = 1'b0;
    tx_busy  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_grant_active", 32'(grant_active), 32'd0);
    chk("rst_pulses", 32'({pkt_overflow, pkt_abort}), 32'd0);
    next_cycle();
    nRST = 1'b1;

    // Round-robin with every requester pending.
    next_cycle();
    tx_ready = 1'b1;
    push(0, 8'h10, 1'b1); push(0, 8'h11, 1'b1);
    push(1, 8'h20, 1'b1); push(2, 8'h30, 1'b1); push(3, 8'h40, 1'b1);
`ifdef USB_TX_ARB_PRIO_EN
    expect_x(0, 8'h10); expect_x(0, 8'h11); expect_x(1, 8'h20); expect_x(2, 8'h30); expect_x(3, 8'h40);
`else
    expect_x(0, 8'h10); expect_x(1, 8'h20); expect_x(2, 8'h30); expect_x(3, 8'h40); expect_x(0, 8'h11);
`endif
    settle();

    // Single 3-byte packet, EOP hold, then exact gap length.
    next_cycle();
    push(2, 8'hA5, 1'b0); push(2, 8'h5A, 1'b0); push(2, 8'hFF, 1'b1);
    expect_x(2, 8'hA5); expect_x(2, 8'h5A); expect_x(2, 8'hFF);
    @(negedge clk);
    chk("sp_latency0", 32'(tx_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("sp_valid1", 32'(tx_valid), 32'd1);
    chk("sp_grant", 32'(grant_id), 32'd2);
    next_cycle();
    tx_busy = 1'b1;
    @(negedge clk);
    chk("sp_valid2", 32'(tx_valid), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("sp_valid3", 32'(tx_valid), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("sp_eop_valid", 32'(tx_valid), 32'd0);
    chk("sp_eop_active", 32'(grant_active), 32'd1);
    repeat (4) next_cycle();
    tx_busy = 1'b0;
    @(negedge clk);
    chk("sp_eop_last", 32'(grant_active), 32'd1);
    next_cycle();
    push(1, 8'h3C, 1'b1);
    expect_x(1, 8'h3C);
    @(negedge clk);
    chk("sp_gap_start", 32'(grant_active), 32'd0);
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      @(negedge clk);
      chk("sp_gap_hold", 32'({tx_valid, grant_active}), 32'd0);
    end
    next_cycle();
    @(negedge clk);
    chk("sp_regrant", 32'({grant_active, tx_valid}), 32'd3);
    chk("sp_regrant_id", 32'(grant_id), 32'd1);
    settle();

    // Backpressure on a 4-byte packet.
    h = head[3];
    next_cycle();
    push(3, 8'h01, 1'b0); push(3, 8'h02, 1'b0); push(3, 8'h03, 1'b0); push(3, 8'h04, 1'b1);
    expect_x(3, 8'h01); expect_x(3, 8'h02); expect_x(3, 8'h03); expect_x(3, 8'h04);
    for (int k = 0; k < 14; k++) begin
      next_cycle();
      tx_ready = ~tx_ready;
    end
    tx_ready = 1'b1;
    settle();
    chk("bp_acks", 32'(head[3] - h), 32'd4);

    // Overflow: 6 bytes without last, limit 4.
    h = head[0];
    next_cycle();
    for (int k = 0; k < 6; k++) push(0, 8'(8'h60 + k), 1'b0);
    for (int k = 0; k < 4; k++) expect_x(0, 8'(8'h60 + k));
    repeat (4) next_cycle();
    next_cycle();
    @(negedge clk);
    chk("ovf_pulse", 32'(pkt_overflow), 32'd1);
    chk("ovf_valid", 32'(tx_valid), 32'd0);
    chk("ovf_active", 32'(grant_active), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("ovf_pulse_end", 32'(pkt_overflow), 32'd0);
    chk("ovf_acks", 32'(head[0] - h), 32'd4);
    tail[0] = head[0];
    settle();

    // Abort: requester runs dry after two bytes.
    next_cycle();
    push(1, 8'h71, 1'b0); push(1, 8'h72, 1'b0);
    expect_x(1, 8'h71); expect_x(1, 8'h72);
    repeat (3) next_cycle();
    @(negedge clk);
    chk("abt_wait_valid", 32'(tx_valid), 32'd0);
    chk("abt_not_yet", 32'(pkt_abort), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("abt_pulse", 32'(pkt_abort), 32'd1);
    chk("abt_valid", 32'(tx_valid), 32'd0);
    chk("abt_no_ovf", 32'(pkt_overflow), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("abt_pulse_end", 32'(pkt_abort), 32'd0);
    settle();

    // Asynchronous reset in the middle of a stalled packet.
    tx_ready = 1'b0;
    next_cycle();
    push(2, 8'hC1, 1'b0); push(2, 8'hC2, 1'b0); push(2, 8'hC3, 1'b0); push(2, 8'hC4, 1'b1);
    repeat (2) next_cycle();
    @(negedge clk);
    chk("rs_sending", 32'({grant_active, tx_valid}), 32'd3);
    #2;
    nRST = 1'b0;
    #1;
    chk("rs_tx_valid", 32'(tx_valid), 32'd0);
    chk("rs_tx_data", 32'(tx_data), 32'd0);
    chk("rs_grant", 32'({grant_id, grant_active}), 32'd0);
    chk("rs_req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < int'(NR); i++) tail[i] = head[i];
    tx_ready = 1'b1;
    @(negedge clk);
    next_cycle();
    nRST = 1'b1;
    push(3, 8'h90, 1'b1); push(0, 8'h80, 1'b1);
    expect_x(0, 8'h80); expect_x(3, 8'h90);
    next_cycle();
    @(negedge clk);
    chk("rs_first_grant", 32'(grant_id), 32'd0);
    settle();

    // Requester 0 and 1 contend right after requester 0 was served.
    next_cycle();
    push(0, 8'hA0, 1'b1);
    expect_x(0, 8'hA0);
    settle();
    next_cycle();
    push(0, 8'hB0, 1'b1); push(1, 8'hB1, 1'b1);
`ifdef USB_TX_ARB_PRIO_EN
    expect_x(0, 8'hB0); expect_x(1, 8'hB1);
`else
    expect_x(1, 8'hB1); expect_x(0, 8'hB0);
`endif
    next_cycle();
    @(negedge clk);
`ifdef USB_TX_ARB_PRIO_EN
    chk("prio_grant", 32'(grant_id), 32'd0);
`else
    chk("prio_grant", 32'(grant_id), 32'd1);
`endif
    settle();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
